// File: rtl/aes_encipher_round_engine.sv
// Iterative AES encipher round engine with SBOX_WORDS parallel S-box lanes.
// Optional macro AES_ENC_RESULT_REG_EN adds a result register that holds new_block stable.
module aes_encipher_round_engine #(
    parameter int unsigned SBOX_WORDS = 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic [1:0]              keylen,
    output logic [3:0]              round,
    input  logic [127:0]            round_key,
    input  logic [127:0]            block,
    output logic [32*SBOX_WORDS-1:0] sboxw,
    input  logic [32*SBOX_WORDS-1:0] new_sboxw,
    output logic [127:0]            new_block,
    output logic                    ready,
    output logic                    done
);

    generate
        if (!(SBOX_WORDS == 1 || SBOX_WORDS == 2 || SBOX_WORDS == 4)) begin : gen_bad_sbox_words
            $error("SBOX_WORDS must be 1, 2 or 4");
        end
    endgenerate

    localparam int unsigned STEPS    = 4 / SBOX_WORDS;
    localparam logic [1:0]  CTR_LAST = 2'(STEPS - 1);

    typedef enum logic [1:0] {IDLE, INIT, SBOX, MAIN} state_t;

    state_t       state, state_next;
    logic [127:0] block_reg, block_next;
    logic [1:0]   ctr, ctr_next;
    logic [1:0]   keylen_reg, keylen_next;
    logic [3:0]   round_next, nr;
    logic         ready_next, done_next;
    logic [127:0] shifted, mixed;

    function automatic logic [7:0] gm2(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm3(input logic [7:0] b);
        return gm2(b) ^ b;
    endfunction

    function automatic logic [31:0] mix_word(input logic [31:0] w);
        logic [7:0] b0, b1, b2, b3;
        b0 = w[31:24];
        b1 = w[23:16];
        b2 = w[15:8];
        b3 = w[7:0];
        return {gm2(b0) ^ gm3(b1) ^ b2 ^ b3,
                b0 ^ gm2(b1) ^ gm3(b2) ^ b3,
                b0 ^ b1 ^ gm2(b2) ^ gm3(b3),
                gm3(b0) ^ b1 ^ b2 ^ gm2(b3)};
    endfunction

    // Byte i of the state sits at [127-8i -: 8], column-major (i = 4*col + row).
    function automatic logic [127:0] shift_rows(input logic [127:0] x);
        logic [127:0] y;
        y = '0;
        for (int unsigned c = 0; c < 4; c++) begin
            for (int unsigned r = 0; r < 4; r++) begin
                y[127-8*(4*c+r) -: 8] = x[127-8*(4*((c+r)%4)+r) -: 8];
            end
        end
        return y;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] x);
        logic [127:0] y;
        y = '0;
        for (int unsigned c = 0; c < 4; c++) begin
            y[127-32*c -: 32] = mix_word(x[127-32*c -: 32]);
        end
        return y;
    endfunction

    always_comb begin
        case (keylen_reg)
            2'b00:   nr = 4'd10;
            2'b01:   nr = 4'd12;
            default: nr = 4'd14;
        endcase
    end

    assign shifted = shift_rows(block_reg);
    assign mixed   = mix_columns(shifted);

    always_comb begin
        int unsigned idx;
        idx         = 0;
        state_next  = state;
        block_next  = block_reg;
        ctr_next    = ctr;
        keylen_next = keylen_reg;
        round_next  = round;
        ready_next  = ready;
        done_next   = 1'b0;
        sboxw       = '0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    keylen_next = keylen;
                    ready_next  = 1'b0;
                    round_next  = 4'd0;
                    state_next  = INIT;
                end
            end
            INIT: begin
                block_next = block ^ round_key;
                round_next = 4'd1;
                ctr_next   = '0;
                state_next = SBOX;
            end
            SBOX: begin
                // Word 0 is the most significant word of block_reg.
                for (int unsigned k = 0; k < SBOX_WORDS; k++) begin
                    idx = 32'(ctr) * SBOX_WORDS + k;
                    sboxw[32*k +: 32]              = block_reg[32*(3-idx) +: 32];
                    block_next[32*(3-idx) +: 32]   = new_sboxw[32*k +: 32];
                end
                ctr_next = ctr + 2'd1;
                if (ctr == CTR_LAST) begin
                    state_next = MAIN;
                end
            end
            MAIN: begin
                if (round == nr) begin
                    block_next = shifted ^ round_key;
                    ready_next = 1'b1;
                    done_next  = 1'b1;
                    round_next = 4'd0;
                    state_next = IDLE;
                end else begin
                    block_next = mixed ^ round_key;
                    round_next = round + 4'd1;
                    ctr_next   = '0;
                    state_next = SBOX;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            block_reg  <= '0;
            ctr        <= '0;
            keylen_reg <= '0;
            round      <= '0;
            ready      <= 1'b1;
            done       <= 1'b0;
        end else begin
            state      <= state_next;
            block_reg  <= block_next;
            ctr        <= ctr_next;
            keylen_reg <= keylen_next;
            round      <= round_next;
            ready      <= ready_next;
            done       <= done_next;
        end
    end

`ifdef AES_ENC_RESULT_REG_EN
    logic [127:0] result_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            result_reg <= '0;
        end else if (done_next) begin
            result_reg <= block_next;
        end
    end

    assign new_block = result_reg;
`else
    assign new_block = block_reg;
`endif

endmodule

// File: tb/tb_aes_encipher_round_engine.sv
// Bench for aes_encipher_round_engine: three instances (SBOX_WORDS 1/2/4) against a byte-level AES model.
// The bench acts as both the key store and the external S-box array.
module tb_aes_encipher_round_engine;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    logic         start_s  [3];
    logic [1:0]   keylen_s [3];
    logic [3:0]   round_s  [3];
    logic [127:0] blk_s    [3];
    logic [127:0] nb_s     [3];
    logic         ready_s  [3];
    logic         done_s   [3];
    logic [127:0] sbw_s    [3];

    logic [7:0]   sbox_tab [256];
    logic [127:0] rk_tab   [3][15];
    int           key_gen  [3];
    int           tab_gen = 0;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [127:0] PT      = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] PT2     = 128'h0123456789abcdeffedcba9876543210;
    localparam logic [255:0] KEY128  = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [255:0] KEY192  = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
    localparam logic [255:0] KEY256  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] CT128   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT192   = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] CT256   = 128'h8ea2b7ca516745bfeafc49904b496089;

    for (genvar g = 0; g < 3; g++) begin : gen_dut
        localparam int unsigned SW = 1 << g;
        logic [32*SW-1:0] sw_o;
        logic [32*SW-1:0] nsw_i;
        logic [127:0]     rk_i;

        aes_encipher_round_engine #(.SBOX_WORDS(SW)) dut (
            .clk       (clk),
            .reset_n   (reset_n),
            .start     (start_s[g]),
            .keylen    (keylen_s[g]),
            .round     (round_s[g]),
            .round_key (rk_i),
            .block     (blk_s[g]),
            .sboxw     (sw_o),
            .new_sboxw (nsw_i),
            .new_block (nb_s[g]),
            .ready     (ready_s[g]),
            .done      (done_s[g])
        );

        assign sbw_s[g] = 128'(sw_o);

        always @(sw_o or tab_gen) begin
            for (int i = 0; i < 4*SW; i++) nsw_i[8*i +: 8] = sbox_tab[sw_o[8*i +: 8]];
        end

        always @(round_s[g] or key_gen[g]) rk_i = rk_tab[g][round_s[g]];
    end

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = xt(a);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [15:0] d;
        d = {x, x} << n;
        return d[15:8];
    endfunction

    // S-box from first principles: multiplicative inverse then affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox_tab[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
        tab_gen++;
    endtask

    function automatic int nr_of(input logic [1:0] kl);
        return (kl == 2'b00) ? 10 : (kl == 2'b01) ? 12 : 14;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox_tab[w[31:24]], sbox_tab[w[23:16]], sbox_tab[w[15:8]], sbox_tab[w[7:0]]};
    endfunction

    task automatic load_key(input int g, input logic [1:0] kl, input logic [255:0] key);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rcon;
        int nk;
        nk   = nr_of(kl) - 6;
        rcon = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < 4*(nk+7); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t    = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
                rcon = xt(rcon);
            end else if (nk == 8 && i % nk == 4) begin
                t = sub_word(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r <= nk + 6; r++) rk_tab[g][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        key_gen[g]++;
    endtask

    function automatic logic [127:0] model_encrypt(input int g, input logic [1:0] kl, input logic [127:0] pt);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [127:0] x;
        logic [7:0]   a0, a1, a2, a3;
        int nr;
        nr = nr_of(kl);
        x  = pt ^ rk_tab[g][0];
        for (int i = 0; i < 16; i++) s[i] = x[127-8*i -: 8];
        for (int rnd = 1; rnd <= nr; rnd++) begin
            for (int i = 0; i < 16; i++) s[i] = sbox_tab[s[i]];
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++) t[4*c+row] = s[4*((c+row)%4)+row];
            s = t;
            if (rnd < nr) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                    s[4*c]   = gmul(8'h02, a0) ^ gmul(8'h03, a1) ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ gmul(8'h02, a1) ^ gmul(8'h03, a2) ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ gmul(8'h02, a2) ^ gmul(8'h03, a3);
                    s[4*c+3] = gmul(8'h03, a0) ^ a1 ^ a2 ^ gmul(8'h02, a3);
                end
            end
            x = rk_tab[g][rnd];
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ x[127-8*i -: 8];
        end
        for (int i = 0; i < 16; i++) x[127-8*i -: 8] = s[i];
        return x;
    endfunction

    // Drives one encryption; returns ciphertext at ready rise, edge count and done-pulse count.
    task automatic run_enc(input int g, input logic [1:0] kl, input logic [127:0] pt, input int disturb_at,
                           output logic [127:0] ct, output int lat, output int dones);
        keylen_s[g] = kl;
        blk_s[g]    = pt;
        @(negedge clk);
        start_s[g] = 1'b1;
        @(posedge clk); #1;
        start_s[g] = 1'b0;
        lat   = 1;
        dones = done_s[g] ? 1 : 0;
        while (!ready_s[g] && lat < 300) begin
            if (disturb_at != 0 && lat == disturb_at) begin
                start_s[g]  = 1'b1;
                keylen_s[g] = ~kl;
                blk_s[g]    = ~pt;
            end else begin
                start_s[g] = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
            if (done_s[g]) dones++;
        end
        start_s[g] = 1'b0;
        ct = nb_s[g];
        @(posedge clk); #1;
        if (done_s[g]) dones++;
    endtask

    task automatic test_reset();
        #3 reset_n = 1'b0;
        #4;
        for (int g = 0; g < 3; g++) begin
            n_checks += 5;
            if (ready_s[g] !== 1'b1) begin n_fail++; $display("FAIL reset_ready[%0d]: got %b expected 1", g, ready_s[g]); end
            if (done_s[g] !== 1'b0) begin n_fail++; $display("FAIL reset_done[%0d]: got %b expected 0", g, done_s[g]); end
            if (round_s[g] !== 4'd0) begin n_fail++; $display("FAIL reset_round[%0d]: got %0d expected 0", g, round_s[g]); end
            if (nb_s[g] !== 128'h0) begin n_fail++; $display("FAIL reset_new_block[%0d]: got %h expected 0", g, nb_s[g]); end
            if (sbw_s[g] !== 128'h0) begin n_fail++; $display("FAIL reset_sboxw[%0d]: got %h expected 0", g, sbw_s[g]); end
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_known_vectors();
        logic [127:0] ct;
        logic [127:0] exp_ct [3];
        logic [255:0] keys   [3];
        int exp_lat [3];
        int lat, dn;
        exp_ct[0] = CT128; exp_ct[1] = CT192; exp_ct[2] = CT256;
        keys[0] = KEY128;  keys[1] = KEY192;  keys[2] = KEY256;
        exp_lat[0] = 52;   exp_lat[1] = 38;   exp_lat[2] = 30;
        for (int g = 0; g < 3; g++) begin
            load_key(g, 2'(g), keys[g]);
            run_enc(g, 2'(g), PT, 0, ct, lat, dn);
            n_checks += 4;
            if (ct !== exp_ct[g]) begin n_fail++; $display("FAIL vector_ct[%0d]: got %h expected %h", g, ct, exp_ct[g]); end
            if (ct !== model_encrypt(g, 2'(g), PT)) begin n_fail++; $display("FAIL vector_model[%0d]: got %h expected %h", g, ct, model_encrypt(g, 2'(g), PT)); end
            if (lat != exp_lat[g]) begin n_fail++; $display("FAIL vector_latency[%0d]: got %0d expected %0d", g, lat, exp_lat[g]); end
            if (dn != 1) begin n_fail++; $display("FAIL vector_done_pulses[%0d]: got %0d expected 1", g, dn); end
        end
    endtask

    task automatic test_random();
        logic [127:0] ct, pt, exp;
        logic [255:0] key;
        logic [1:0]   kl;
        int lat, dn, g, exp_lat;
        for (int it = 0; it < 9; it++) begin
            g   = it % 3;
            kl  = 2'($urandom_range(0, 3));
            key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            pt  = {$urandom, $urandom, $urandom, $urandom};
            load_key(g, kl, key);
            exp     = model_encrypt(g, kl, pt);
            exp_lat = 2 + nr_of(kl) * ((4 >> g) + 1);
            run_enc(g, kl, pt, 0, ct, lat, dn);
            n_checks += 3;
            if (ct !== exp) begin n_fail++; $display("FAIL random_ct[%0d] kl=%0d: got %h expected %h", g, kl, ct, exp); end
            if (lat != exp_lat) begin n_fail++; $display("FAIL random_latency[%0d] kl=%0d: got %0d expected %0d", g, kl, lat, exp_lat); end
            if (dn != 1) begin n_fail++; $display("FAIL random_done_pulses[%0d]: got %0d expected 1", g, dn); end
        end
    endtask

    task automatic test_busy_ignore();
        logic [127:0] ct;
        int lat, dn;
        load_key(0, 2'b00, KEY128);
        run_enc(0, 2'b00, PT, 10, ct, lat, dn);
        n_checks += 3;
        if (ct !== CT128) begin n_fail++; $display("FAIL busy_ct: got %h expected %h", ct, CT128); end
        if (lat != 52) begin n_fail++; $display("FAIL busy_latency: got %0d expected 52", lat); end
        if (dn != 1) begin n_fail++; $display("FAIL busy_done_pulses: got %0d expected 1", dn); end
    endtask

    task automatic test_back_to_back();
        logic [127:0] ct1, ct2, mid, exp2;
        logic stable;
        int cyc;
        load_key(0, 2'b00, KEY128);
        exp2 = model_encrypt(0, 2'b00, PT2);
        keylen_s[0] = 2'b00;
        blk_s[0]    = PT;
        @(negedge clk);
        start_s[0] = 1'b1;
        @(posedge clk); #1;
        cyc = 1;
        while (!ready_s[0] && cyc < 300) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == 5) blk_s[0] = PT2;
        end
        ct1 = nb_s[0];
        n_checks += 3;
        if (ct1 !== CT128) begin n_fail++; $display("FAIL b2b_first_ct: got %h expected %h", ct1, CT128); end
        if (cyc != 52) begin n_fail++; $display("FAIL b2b_first_latency: got %0d expected 52", cyc); end
        if (done_s[0] !== 1'b1) begin n_fail++; $display("FAIL b2b_first_done: got %b expected 1", done_s[0]); end
        @(posedge clk); #1;
        start_s[0] = 1'b0;
        n_checks += 2;
        if (ready_s[0] !== 1'b0) begin n_fail++; $display("FAIL b2b_second_accept: ready got %b expected 0", ready_s[0]); end
        if (done_s[0] !== 1'b0) begin n_fail++; $display("FAIL b2b_done_width: got %b expected 0", done_s[0]); end
        cyc    = 1;
        stable = 1'b1;
        mid    = '0;
        while (!ready_s[0] && cyc < 300) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == 10) mid = nb_s[0];
            if (!ready_s[0] && nb_s[0] !== ct1) stable = 1'b0;
        end
        ct2 = nb_s[0];
        n_checks += 3;
        if (ct2 !== exp2) begin n_fail++; $display("FAIL b2b_second_ct: got %h expected %h", ct2, exp2); end
        if (cyc != 52) begin n_fail++; $display("FAIL b2b_second_latency: got %0d expected 52", cyc); end
`ifdef AES_ENC_RESULT_REG_EN
        if (stable !== 1'b1) begin n_fail++; $display("FAIL result_hold: got %b expected 1 (mid=%h)", stable, mid); end
`else
        if (mid === ct1) begin n_fail++; $display("FAIL result_live: got %h expected value other than %h (stable=%b)", mid, ct1, stable); end
`endif
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        logic [127:0] ct;
        int lat, dn, cyc;
        load_key(0, 2'b00, KEY128);
        keylen_s[0] = 2'b00;
        blk_s[0]    = PT;
        @(negedge clk);
        start_s[0] = 1'b1;
        @(posedge clk); #1;
        start_s[0] = 1'b0;
        cyc = 1;
        dn  = 0;
        while (cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
            if (done_s[0]) dn++;
        end
        reset_n = 1'b0;
        #1;
        n_checks += 4;
        if (ready_s[0] !== 1'b1) begin n_fail++; $display("FAIL abort_ready: got %b expected 1", ready_s[0]); end
        if (nb_s[0] !== 128'h0) begin n_fail++; $display("FAIL abort_new_block: got %h expected 0", nb_s[0]); end
        if (round_s[0] !== 4'd0) begin n_fail++; $display("FAIL abort_round: got %0d expected 0", round_s[0]); end
        if (done_s[0] !== 1'b0) begin n_fail++; $display("FAIL abort_done: got %b expected 0", done_s[0]); end
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (done_s[0]) dn++;
        end
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done_s[0]) dn++;
        end
        n_checks += 1;
        if (dn != 0) begin n_fail++; $display("FAIL abort_no_done: got %0d pulses expected 0", dn); end
        run_enc(0, 2'b00, PT, 0, ct, lat, dn);
        n_checks += 2;
        if (ct !== CT128) begin n_fail++; $display("FAIL abort_restart_ct: got %h expected %h", ct, CT128); end
        if (lat != 52) begin n_fail++; $display("FAIL abort_restart_latency: got %0d expected 52", lat); end
    endtask

    initial begin
        reset_n = 1'b1;
        for (int g = 0; g < 3; g++) begin
            start_s[g]  = 1'b0;
            keylen_s[g] = 2'b00;
            blk_s[g]    = '0;
            key_gen[g]  = 0;
        end
        build_sbox();
        test_reset();
        test_known_vectors();
        test_random();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
